// File: rtl/rr_mutex_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mutex_arbiter
//   N-way clocked mutual-exclusion arbiter with a four-phase req/gnt handshake.
//   Each request bit passes through SYNC synchroniser flops, then a three-state
//   FSM (IDLE -> OWN -> GAP -> IDLE) grants one requester at a time. There is
//   always at least one all-zero grant cycle between two owners. The winner is
//   either the lowest set index (MODE=0) or the first set index at or above a
//   rotating pointer (MODE=1).
//
//   Reset is asserted asynchronously. It must be released synchronously to clk
//   by the surrounding reset logic.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-low reset
//   req      in   N      per-channel request (raise, hold until gnt, drop)
//   gnt      out  N      registered one-hot-or-zero grant
//   gnt_idx  out  IDX_W  index of the current or most recent owner
//   busy     out  1      high while the FSM is not in IDLE
// -----------------------------------------------------------------------------
module rr_mutex_arbiter #(
  parameter int unsigned    N     = 4,
  parameter bit             MODE  = 1'b1,
  parameter int unsigned    SYNC  = 2,
  localparam int unsigned   IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [N-1:0]     w_req_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_gnt;
  logic [N-1:0]     w_gnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_found;
  logic [IDX_W-1:0] w_win;

  // ---------------------------------------------------------------------------
  // Request synchroniser
  // ---------------------------------------------------------------------------
  generate
    if (SYNC == 0) begin : g_nosync
      assign w_req_s = req;
    end else begin : g_sync
      logic [N-1:0] r_sync [SYNC];

      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // the pre-edge value of its neighbour; blocking here would collapse the
      // whole chain into a single stage.
      // NOTE: the synchroniser flops are reset so a request that was high
      // before reset cannot produce a grant before it has been re-sampled.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < int'(SYNC); s++) r_sync[s] <= '0;
        end else begin
          r_sync[0] <= req;
          for (int s = 1; s < int'(SYNC); s++) r_sync[s] <= r_sync[s-1];
        end
      end

      assign w_req_s = r_sync[SYNC-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Winner selection: scan N positions starting at the pointer (round-robin)
  // or at 0 (fixed priority), wrapping modulo N.
  // ---------------------------------------------------------------------------
  always_comb begin : p_pick
    int unsigned idx;
    // NOTE: every variable gets a default before any conditional assignment;
    // a path that leaves one unassigned would infer a latch.
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = k;
      if (MODE) idx = idx + 32'(r_ptr);
      if (idx >= N) idx = idx - N;
      if (!w_found && w_req_s[idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gnt_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_idx_nxt        = w_win;
          w_ptr_nxt        = (w_win == IDX_W'(N - 1)) ? '0 : w_win + IDX_W'(1);
          w_state_nxt      = ST_OWN;
        end
      end
      ST_OWN: begin
        // The owner's request has dropped when it no longer overlaps the grant.
        if ((w_req_s & r_gnt) == '0) begin
          w_gnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign busy    = (r_state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(gnt));

  a_rise_from_idle: assert property (@(posedge clk) disable iff (!rst)
    ((gnt & ~$past(gnt)) != '0) |-> ($past(r_state) == ST_IDLE));

  a_gap_between_owners: assert property (@(posedge clk) disable iff (!rst)
    (($past(gnt) != '0) && (gnt != '0)) |-> (gnt == $past(gnt)));

  a_idle_no_gnt: assert property (@(posedge clk) disable iff (!rst)
    !busy |-> (gnt == '0));

endmodule

// File: tb/tb_rr_mutex_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mutex_arbiter
//   Directed bench for rr_mutex_arbiter. Instance A is round-robin with a
//   two-flop synchroniser; instance B is fixed priority with no synchroniser.
//   Both share clk and rst. Expected values are hand-computed cycle by cycle.
// -----------------------------------------------------------------------------
module tb_rr_mutex_arbiter;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst = 1'b0;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_idx_a, gnt_idx_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  rr_mutex_arbiter #(.N(4), .MODE(1'b1), .SYNC(2)) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .req     (req_a),
    .gnt     (gnt_a),
    .gnt_idx (gnt_idx_a),
    .busy    (busy_a)
  );

  rr_mutex_arbiter #(.N(4), .MODE(1'b0), .SYNC(0)) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .req     (req_b),
    .gnt     (gnt_b),
    .gnt_idx (gnt_idx_b),
    .busy    (busy_b)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset pulse with synchronous release (released 1 unit after an edge).
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  int         rr_order [6] = '{0, 1, 2, 3, 0, 1};
  int         fp_order [6] = '{0, 0, 0, 1, 2, 3};
  bit         fp_rearm [6] = '{1, 1, 0, 0, 0, 0};
  logic [3:0] prev_a, prev_b;
  int         pend [4];

  initial begin
    // ---- reset state with clock running ----
    #1;
    check("rst_gnt_a", gnt_a, 4'b0000);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_idx_a", gnt_idx_a, 2'd0);
    step(2);
    rst = 1'b1;

    // ---- single requester, SYNC=2 latency ----
    req_a = 4'b0100;                 // before edge 0
    step(2);                         // after edge 1
    check("single_pre_gnt", gnt_a, 4'b0000);
    step(1);                         // after edge 2
    check("single_gnt", gnt_a, 4'b0100);
    check("single_idx", gnt_idx_a, 2'd2);
    check("single_busy", busy_a, 1'b1);
    step(2);
    req_a = 4'b0000;                 // before edge 5
    step(2);                         // after edge 6
    check("single_hold", gnt_a, 4'b0100);
    step(1);                         // after edge 7
    check("single_rel_gnt", gnt_a, 4'b0000);
    check("single_rel_busy", busy_a, 1'b1);
    step(1);                         // after edge 8
    check("single_idle_busy", busy_a, 1'b0);
    check("single_idle_idx", gnt_idx_a, 2'd2);

    // ---- async reset while owning, no clock ----
    req_a = 4'b0100;
    step(3);
    check("areset_pre_gnt", gnt_a, 4'b0100);
    req_a = 4'b1101;                 // pointer now 3; 0 and 3 also pending
    @(negedge clk);
    clk_en = 1'b0;
    #20 rst = 1'b0;
    #1;
    check("areset_gnt", gnt_a, 4'b0000);
    check("areset_busy", busy_a, 1'b0);
    check("areset_idx", gnt_idx_a, 2'd0);
    #10 clk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    step(2);
    check("areset_wait", gnt_a, 4'b0000);
    step(1);
    check("areset_first_gnt", gnt_a, 4'b0001);
    check("areset_first_idx", gnt_idx_a, 2'd0);
    req_a = 4'b0000;
    step(8);
    check("areset_drain", busy_a, 1'b0);

    // ---- round-robin fairness on A ----
    do_reset();
    req_a = 4'b1111;
    step(3);
    for (int k = 0; k < 6; k++) begin
      check("rr_gnt", gnt_a, 32'(4'b0001 << rr_order[k]));
      check("rr_idx", gnt_idx_a, 32'(rr_order[k]));
      step(1);
      req_a[rr_order[k]] = 1'b0;
      step(3);
      check("rr_rel_gnt", gnt_a, 4'b0000);
      check("rr_rel_busy", busy_a, 1'b1);
      req_a[rr_order[k]] = 1'b1;
      step(1);
      check("rr_gap_gnt", gnt_a, 4'b0000);
      check("rr_gap_busy", busy_a, 1'b0);
      step(1);
    end
    req_a = 4'b0000;
    step(10);
    check("rr_drain", busy_a, 1'b0);

    // ---- fixed priority on B ----
    req_b = 4'b1111;
    step(1);
    for (int k = 0; k < 6; k++) begin
      check("fp_gnt", gnt_b, 32'(4'b0001 << fp_order[k]));
      check("fp_idx", gnt_idx_b, 32'(fp_order[k]));
      step(1);
      req_b[fp_order[k]] = 1'b0;
      step(1);
      check("fp_rel_gnt", gnt_b, 4'b0000);
      check("fp_rel_busy", busy_b, 1'b1);
      if (fp_rearm[k]) req_b[fp_order[k]] = 1'b1;
      step(1);
      check("fp_gap_gnt", gnt_b, 4'b0000);
      check("fp_gap_busy", busy_b, 1'b0);
      step(1);
    end
    check("fp_none_left", gnt_b, 4'b0000);

    // ---- simultaneous release/request, SYNC=0 ----
    req_b = 4'b0010;
    step(1);
    check("simul_own1", gnt_b, 4'b0010);
    req_b = 4'b1000;                 // drop 1 and raise 3 before the same edge
    step(1);
    check("simul_rel", gnt_b, 4'b0000);
    check("simul_rel_busy", busy_b, 1'b1);
    step(1);
    check("simul_gap", gnt_b, 4'b0000);
    check("simul_gap_busy", busy_b, 1'b0);
    step(1);
    check("simul_own3", gnt_b, 4'b1000);
    check("simul_idx3", gnt_idx_b, 2'd3);
    req_b = 4'b0000;
    step(3);
    check("simul_drain", busy_b, 1'b0);

    // ---- randomised stress with protocol-obeying requesters ----
    do_reset();
    prev_a = '0;
    prev_b = '0;
    foreach (pend[i]) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset();
        prev_a = '0;
        prev_b = '0;
        foreach (pend[i]) pend[i] = 0;
      end
      step(1);
      check("st_onehot_a", $onehot0(gnt_a), 1'b1);
      check("st_onehot_b", $onehot0(gnt_b), 1'b1);
      check("st_idle_gnt_a", !busy_a && gnt_a != 4'b0000, 1'b0);
      check("st_idle_gnt_b", !busy_b && gnt_b != 4'b0000, 1'b0);
      check("st_gap_a", prev_a != 4'b0000 && gnt_a != 4'b0000 && gnt_a != prev_a, 1'b0);
      check("st_gap_b", prev_b != 4'b0000 && gnt_b != 4'b0000 && gnt_b != prev_b, 1'b0);
      for (int i = 0; i < 4; i++) begin
        if (gnt_a[i]) pend[i] = 0;
        else if (req_a[i] && (gnt_a & ~prev_a) != 4'b0000) begin
          pend[i]++;
          check("st_fair_a", pend[i] <= 4, 1'b1);
        end
      end
      prev_a = gnt_a;
      prev_b = gnt_b;
      for (int i = 0; i < 4; i++) begin
        if (!req_a[i] && !gnt_a[i] && $urandom_range(3) == 0) req_a[i] = 1'b1;
        else if (req_a[i] && gnt_a[i] && $urandom_range(1) == 0) req_a[i] = 1'b0;
        if (!req_b[i] && !gnt_b[i] && $urandom_range(3) == 0) req_b[i] = 1'b1;
        else if (req_b[i] && gnt_b[i] && $urandom_range(1) == 0) req_b[i] = 1'b0;
      end
    end
    req_a = 4'b0000;
    req_b = 4'b0000;
    step(10);
    check("st_drain_a", busy_a, 1'b0);
    check("st_drain_b", busy_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
